// File: rtl/sequencer_pkg.sv
// Shared types for the basic processor control unit: opcode and state
// encodings plus the control word that groups every datapath strobe.
package sequencer_pkg;

  localparam int WORD_W = 8;
  localparam int OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    OP_LOAD  = 3'd0,
    OP_STORE = 3'd1,
    OP_ADD   = 3'd2,
    OP_SUB   = 3'd3,
    OP_BNE   = 3'd4,
    OP_JMP   = 3'd5,
    OP_NOP   = 3'd6,
    OP_HALT  = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  typedef struct packed {
    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic load_ir;
    logic load_pc;
    logic inc_pc;
    logic load_acc;
    logic acc_sel;
    logic alu_sub;
    logic halted;
  } ctrl_t;

endpackage

// File: rtl/seq_decode.sv
// Combinational control decoder: maps the current state, opcode, zero flag
// and memory handshake onto the control word and the next state.
module seq_decode
  import sequencer_pkg::*;
(
  input  state_t  state,
  input  opcode_t op,
  input  logic    z_flag,
  input  logic    mem_ready,
  output ctrl_t   ctrl,
  output state_t  next_state
);

  // Strobe and next-state decode; every strobe defaults to 0.
  always_comb begin
    ctrl       = '0;
    next_state = state;
    case (state)
      ST_IDLE: begin
        next_state = ST_FETCH;
      end
      ST_FETCH: begin
        // Instruction read from PC; IR capture and PC increment land
        // together on the completing edge.
        ctrl.mem_req = 1'b1;
        if (mem_ready) begin
          ctrl.load_ir = 1'b1;
          ctrl.load_pc = 1'b1;
          ctrl.inc_pc  = 1'b1;
          next_state   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE, OP_ADD, OP_SUB: next_state = ST_EXEC;
          OP_BNE: begin
            // A taken branch replaces the increment already applied in FETCH.
            ctrl.load_pc = ~z_flag;
            next_state   = ST_FETCH;
          end
          OP_JMP: begin
            ctrl.load_pc = 1'b1;
            next_state   = ST_FETCH;
          end
          OP_NOP:  next_state = ST_FETCH;
          OP_HALT: next_state = ST_HALT;
          default: next_state = ST_FETCH;
        endcase
      end
      ST_EXEC: begin
        // Operand access from the IR address field; request lines stay
        // steady for the whole access because op is held in IR.
        ctrl.mem_req  = 1'b1;
        ctrl.addr_sel = 1'b1;
        ctrl.mem_we   = (op == OP_STORE);
        if (mem_ready) begin
          ctrl.load_acc = (op == OP_LOAD) || (op == OP_ADD) || (op == OP_SUB);
          ctrl.acc_sel  = (op == OP_ADD) || (op == OP_SUB);
          ctrl.alu_sub  = (op == OP_SUB);
          next_state    = ST_FETCH;
        end
      end
      ST_HALT: begin
        ctrl.halted = 1'b1;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/sequencer.sv
// Control unit FSM for the basic processor. Holds only the state register;
// all strobes are a combinational decode of state and current inputs, so an
// asynchronous reset drops any in-flight memory request immediately.
module sequencer
  import sequencer_pkg::*;
(
  input  logic            clock,
  input  logic            n_reset,
  input  logic [OP_W-1:0] op,
  input  logic            z_flag,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            mem_we,
  output logic            addr_sel,
  output logic            load_IR,
  output logic            load_PC,
  output logic            INC_PC,
  output logic            load_ACC,
  output logic            acc_sel,
  output logic            alu_sub,
  output logic            halted
);

  state_t  state;
  state_t  next_state;
  ctrl_t   ctrl;
  opcode_t op_e;

  assign op_e = opcode_t'(op);

  seq_decode u_decode (
    .state      (state),
    .op         (op_e),
    .z_flag     (z_flag),
    .mem_ready  (mem_ready),
    .ctrl       (ctrl),
    .next_state (next_state)
  );

  // State register; reset returns to IDLE asynchronously.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) state <= ST_IDLE;
    else          state <= next_state;
  end

  assign mem_req  = ctrl.mem_req;
  assign mem_we   = ctrl.mem_we;
  assign addr_sel = ctrl.addr_sel;
  assign load_IR  = ctrl.load_ir;
  assign load_PC  = ctrl.load_pc;
  assign INC_PC   = ctrl.inc_pc;
  assign load_ACC = ctrl.load_acc;
  assign acc_sel  = ctrl.acc_sel;
  assign alu_sub  = ctrl.alu_sub;
  assign halted   = ctrl.halted;

endmodule

// File: tb/tb_sequencer.sv
// Directed bench for the sequencer control unit: walks every instruction
// class with hand-computed strobe patterns, wait states, halt and reset abort.
module tb_sequencer;
  import sequencer_pkg::*;

  // Bit positions in the observed control vector
  localparam logic [9:0] REQ = 10'b10_0000_0000;
  localparam logic [9:0] WE  = 10'b01_0000_0000;
  localparam logic [9:0] AS  = 10'b00_1000_0000;
  localparam logic [9:0] IR  = 10'b00_0100_0000;
  localparam logic [9:0] PC  = 10'b00_0010_0000;
  localparam logic [9:0] INC = 10'b00_0001_0000;
  localparam logic [9:0] ACC = 10'b00_0000_1000;
  localparam logic [9:0] SEL = 10'b00_0000_0100;
  localparam logic [9:0] SUB = 10'b00_0000_0010;
  localparam logic [9:0] HLT = 10'b00_0000_0001;
  localparam logic [9:0] NONE = 10'b0;
  localparam logic [9:0] FETCH_DONE = REQ | IR | PC | INC;

  logic            clock;
  logic            n_reset;
  logic [OP_W-1:0] op;
  logic            z_flag;
  logic            mem_ready;
  logic mem_req, mem_we, addr_sel, load_IR, load_PC, INC_PC;
  logic load_ACC, acc_sel, alu_sub, halted;

  int n_pass;
  int n_total;

  sequencer dut (
    .clock     (clock),
    .n_reset   (n_reset),
    .op        (op),
    .z_flag    (z_flag),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .addr_sel  (addr_sel),
    .load_IR   (load_IR),
    .load_PC   (load_PC),
    .INC_PC    (INC_PC),
    .load_ACC  (load_ACC),
    .acc_sel   (acc_sel),
    .alu_sub   (alu_sub),
    .halted    (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [9:0] observed();
    return {mem_req, mem_we, addr_sel, load_IR, load_PC, INC_PC,
            load_ACC, acc_sel, alu_sub, halted};
  endfunction

  task automatic chk(input string tag, input logic [9:0] exp);
    logic [9:0] got;
    got = observed();
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b (req,we,asel,ir,pc,inc,acc,sel,sub,hlt)",
                tag, got, exp);
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive inputs for the current cycle, then sample the decoded strobes
  task automatic step(input string tag, input opcode_t o, input logic z,
                      input logic rdy, input logic [9:0] exp);
    tick();
    op        = o;
    z_flag    = z;
    mem_ready = rdy;
    #1;
    chk(tag, exp);
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    n_reset   = 1'b0;
    op        = OP_LOAD;
    z_flag    = 1'b0;
    mem_ready = 1'b1;
    #2;
    chk("reset_async", NONE);
    tick();
    tick();
    chk("reset_held", NONE);
    n_reset = 1'b1;
    #1;
    chk("idle", NONE);

    // Fetch, then LOAD with two EXEC wait states
    step("fetch_first",   OP_LOAD, 1'b0, 1'b1, FETCH_DONE);
    step("load_decode",   OP_LOAD, 1'b0, 1'b1, NONE);
    step("load_wait1",    OP_LOAD, 1'b0, 1'b0, REQ | AS);
    step("load_wait2",    OP_LOAD, 1'b0, 1'b0, REQ | AS);
    step("load_done",     OP_LOAD, 1'b0, 1'b1, REQ | AS | ACC);

    // SUB and ADD
    step("sub_fetch",     OP_SUB, 1'b0, 1'b1, FETCH_DONE);
    step("sub_decode",    OP_SUB, 1'b0, 1'b1, NONE);
    step("sub_exec",      OP_SUB, 1'b0, 1'b1, REQ | AS | ACC | SEL | SUB);
    step("add_fetch",     OP_ADD, 1'b0, 1'b1, FETCH_DONE);
    step("add_decode",    OP_ADD, 1'b0, 1'b1, NONE);
    step("add_exec",      OP_ADD, 1'b0, 1'b1, REQ | AS | ACC | SEL);

    // Fetch wait state, then branches
    step("fetch_wait",    OP_BNE, 1'b0, 1'b0, REQ);
    step("bne_fetch",     OP_BNE, 1'b0, 1'b1, FETCH_DONE);
    step("bne_taken",     OP_BNE, 1'b0, 1'b1, PC);
    step("bne_nt_fetch",  OP_BNE, 1'b1, 1'b1, FETCH_DONE);
    step("bne_not_taken", OP_BNE, 1'b1, 1'b1, NONE);
    step("jmp_fetch",     OP_JMP, 1'b0, 1'b1, FETCH_DONE);
    step("jmp_decode",    OP_JMP, 1'b0, 1'b1, PC);
    step("nop_fetch",     OP_NOP, 1'b0, 1'b1, FETCH_DONE);
    step("nop_decode",    OP_NOP, 1'b0, 1'b1, NONE);

    // STORE: write only in EXEC, held through a wait state
    step("store_fwait",   OP_STORE, 1'b0, 1'b0, REQ);
    step("store_fetch",   OP_STORE, 1'b0, 1'b1, FETCH_DONE);
    step("store_decode",  OP_STORE, 1'b0, 1'b1, NONE);
    step("store_wait",    OP_STORE, 1'b0, 1'b0, REQ | WE | AS);
    step("store_done",    OP_STORE, 1'b0, 1'b1, REQ | WE | AS);
    step("post_store_fetch", OP_STORE, 1'b0, 1'b1, FETCH_DONE);

    // HALT: stuck with halted=1 regardless of inputs
    step("halt_decode",   OP_HALT, 1'b0, 1'b1, NONE);
    for (int i = 0; i < 20; i++) begin
      step($sformatf("halted_%0d", i), opcode_t'(3'($urandom)),
           1'($urandom), i[0], HLT);
    end

    // Reset leaves HALT; then abort a FETCH wait with a reset pulse
    n_reset = 1'b0;
    #1;
    chk("halt_reset", NONE);
    tick();
    n_reset = 1'b1;
    #1;
    chk("idle_again", NONE);
    step("abort_fwait",   OP_NOP, 1'b0, 1'b0, REQ);
    #2;
    n_reset = 1'b0;
    #1;
    chk("abort_drop", NONE);
    tick();
    n_reset = 1'b1;
    #1;
    chk("abort_idle", NONE);
    step("abort_refetch", OP_NOP, 1'b0, 1'b1, FETCH_DONE);
    step("abort_decode",  OP_NOP, 1'b0, 1'b1, NONE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
